// File: rtl/spi_shift.sv
// SPI master shift engine driven by an external sckgen: it sequences chip
// select, shifts tx_data out on MOSI and assembles the word sampled from MISO.
module spi_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             lsb_first,
  input  logic             sck,
  input  logic             sck_rise,
  input  logic             sck_fall,
  output logic             sck_en,
  output logic             spi_sck,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic             spi_cs_n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] sr_shift;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic             lsb_q, lsb_d;
  logic             miso_q, miso_d;
  logic             sck_en_q, sck_en_d;
  logic             cs_n_q, cs_n_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             shift_in, shift_out, cur_bit, first_bit;

  // CPHA=1 samples and shifts on the same edge, so MISO bypasses miso_q there.
  always_comb begin
    shift_in  = cpha_q ? spi_miso : miso_q;
    sr_shift  = lsb_q ? {shift_in, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], shift_in};
    shift_out = lsb_q ? sr_shift[0] : sr_shift[WIDTH-1];
    cur_bit   = lsb_q ? sr_q[0] : sr_q[WIDTH-1];
    first_bit = lsb_first ? tx_data[0] : tx_data[WIDTH-1];
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    rx_d     = rx_q;
    cnt_d    = cnt_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    lsb_d    = lsb_q;
    miso_d   = miso_q;
    sck_en_d = sck_en_q;
    cs_n_d   = cs_n_q;
    mosi_d   = mosi_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        cnt_d  = '0;
        // busy_q is still high in the done cycle, which keeps that start out
        if (start && !busy_q) begin
          sr_d    = tx_data;
          cpol_d  = cpol;
          cpha_d  = cpha;
          lsb_d   = lsb_first;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          state_d = LEAD;
          if (!cpha) mosi_d = first_bit;
        end
      end
      LEAD: begin
        sck_en_d = 1'b1;
        state_d  = SHIFT;
      end
      SHIFT: begin
        if (sck_fall) begin
          sr_d  = sr_shift;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            sck_en_d = 1'b0;
            state_d  = TRAIL;
          end else if (!cpha_q) begin
            mosi_d = shift_out;
          end
        end else if (sck_rise) begin
          if (cpha_q) mosi_d = cur_bit;
          else        miso_d = spi_miso;
        end
      end
      TRAIL: begin
        cs_n_d  = 1'b1;
        done_d  = 1'b1;
        rx_d    = sr_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      rx_q     <= '0;
      cnt_q    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      miso_q   <= 1'b0;
      sck_en_q <= 1'b0;
      cs_n_q   <= 1'b1;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      rx_q     <= rx_d;
      cnt_q    <= cnt_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      lsb_q    <= lsb_d;
      miso_q   <= miso_d;
      sck_en_q <= sck_en_d;
      cs_n_q   <= cs_n_d;
      mosi_q   <= mosi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sck_en   = sck_en_q;
  assign spi_sck  = (state_q == SHIFT) ? (sck ^ cpol_q) : cpol_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_data  = rx_q;

endmodule

// File: tb/tb_spi_shift.sv
// Bench for spi_shift: models sckgen and an SPI slave, and checks each transfer
// against the bit order and handshake timing expected at the pins.
module tb_spi_shift;

  localparam int WIDTH = 8;

  logic             clk, rst, start;
  logic [WIDTH-1:0] tx_data;
  logic             cpol, cpha, lsb_first;
  logic             sck, sck_rise, sck_fall;
  logic             sck_en, spi_sck, spi_mosi, spi_miso, spi_cs_n, busy, done;
  logic [WIDTH-1:0] rx_data;

  int n_cmp = 0;
  int n_err = 0;
  int baud  = 0;

  bit       cfg_cpol = 0, cfg_cpha = 0, cfg_lsb = 0, cfg_loop = 1;
  logic [7:0] slave_word = 8'h00;
  logic       slave_bit;
  int lead_cnt = 0, trail_cnt = 0, rise_cnt = 0;
  int hi_run = 0, last_hi = 0;
  logic prev_sck = 0, prev_cs_n = 1;
  logic cap_q[$];
  logic [3:0] gen_cnt;

  spi_shift #(.WIDTH(WIDTH)) u_dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .sck(sck), .sck_rise(sck_rise), .sck_fall(sck_fall),
    .sck_en(sck_en), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_cs_n(spi_cs_n), .busy(busy), .done(done), .rx_data(rx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sckgen stand-in: half period of baud+2 clks, sck low whenever en is low
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck <= 1'b0; sck_rise <= 1'b0; sck_fall <= 1'b0; gen_cnt <= 4'd0;
    end else begin
      sck_rise <= 1'b0;
      sck_fall <= 1'b0;
      if (!sck_en) begin
        sck <= 1'b0; gen_cnt <= 4'd0;
      end else if (int'(gen_cnt) == baud + 1) begin
        gen_cnt <= 4'd0;
        sck <= ~sck;
        if (sck) sck_fall <= 1'b1;
        else     sck_rise <= 1'b1;
      end else begin
        gen_cnt <= gen_cnt + 4'd1;
      end
    end
  end

  // slave: counts pin edges, captures MOSI on its sampling edge
  always @(negedge clk) begin
    if (!spi_cs_n && !prev_cs_n && spi_sck != prev_sck) begin
      if (spi_sck != cfg_cpol) begin
        lead_cnt++;
        if (!cfg_cpha) cap_q.push_back(spi_mosi);
      end else begin
        trail_cnt++;
        if (cfg_cpha) cap_q.push_back(spi_mosi);
      end
      if (spi_sck) rise_cnt++;
    end
    if (spi_cs_n) hi_run++;
    else begin
      if (prev_cs_n) last_hi = hi_run;
      hi_run = 0;
    end
    prev_sck  = spi_sck;
    prev_cs_n = spi_cs_n;
  end

  always_comb begin : slave_drive
    int idx;
    idx = cfg_cpha ? ((lead_cnt > 0) ? lead_cnt - 1 : 0) : trail_cnt;
    if (idx > 7) idx = 7;
    slave_bit = cfg_lsb ? slave_word[idx] : slave_word[7 - idx];
  end

  assign spi_miso = cfg_loop ? spi_mosi : slave_bit;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] tx, input bit pol, input bit pha,
                               input bit lsb, input bit loop, input logic [7:0] sw,
                               input bit poke);
    logic [7:0] exp_rx, cap_word;
    int cyc, fall_cnt, fall_cyc, pos;
    bit busy_ok, got_done;
    cfg_cpol = pol; cfg_cpha = pha; cfg_lsb = lsb; cfg_loop = loop; slave_word = sw;
    lead_cnt = 0; trail_cnt = 0; rise_cnt = 0;
    cap_q.delete();
    tx_data = tx; cpol = pol; cpha = pha; lsb_first = lsb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("lead_busy", 32'(busy), 32'(1));
    checkOutput("lead_cs_n", 32'(spi_cs_n), 32'(0));
    checkOutput("lead_sck_en", 32'(sck_en), 32'(0));
    checkOutput("lead_sck_idle", 32'(spi_sck), 32'(pol));
    if (!pha) checkOutput("lead_mosi", 32'(spi_mosi), 32'(lsb ? tx[0] : tx[7]));
    @(negedge clk);
    checkOutput("shift_sck_en", 32'(sck_en), 32'(1));
    cyc = 2; fall_cnt = 0; fall_cyc = -10; busy_ok = 1; got_done = 0;
    while (!got_done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == fall_cyc + 1) begin
        checkOutput("trail_sck_en", 32'(sck_en), 32'(0));
        checkOutput("trail_cs_n", 32'(spi_cs_n), 32'(0));
      end
      if (done) got_done = 1;
      else if (!busy) busy_ok = 0;
      if (sck_fall) begin
        fall_cnt++;
        if (fall_cnt == WIDTH) fall_cyc = cyc;
        if (poke && fall_cnt == 1) begin
          start = 1'b1;
          tx_data = ~tx;
        end
      end
    end
    if (!got_done) begin
      checkOutput("done_timeout", 32'(0), 32'(1));
      return;
    end
    exp_rx = loop ? tx : sw;
    cap_word = 8'h00;
    for (int k = 0; k < cap_q.size() && k < 8; k++) begin
      pos = lsb ? k : 7 - k;
      cap_word[pos] = cap_q[k];
    end
    checkOutput("done_cycle", 32'(cyc), 32'(fall_cyc + 2));
    checkOutput("rx_data", 32'(rx_data), 32'(exp_rx));
    checkOutput("done_busy", 32'(busy), 32'(1));
    checkOutput("done_cs_n", 32'(spi_cs_n), 32'(1));
    checkOutput("done_sck_idle", 32'(spi_sck), 32'(pol));
    checkOutput("busy_span", 32'(busy_ok), 32'(1));
    checkOutput("sck_rises", 32'(rise_cnt), 32'(8));
    checkOutput("mosi_count", 32'(cap_q.size()), 32'(8));
    checkOutput("mosi_bits", 32'(cap_word), 32'(tx));
    @(negedge clk);
    checkOutput("done_pulse", 32'(done), 32'(0));
    checkOutput("idle_busy", 32'(busy), 32'(0));
  endtask

  task automatic abortTransfer();
    int waited;
    bit saw_done, cs_low;
    waited = 0; saw_done = 0; cs_low = 0;
    cfg_cpol = 0; cfg_cpha = 0; cfg_lsb = 0; cfg_loop = 1;
    lead_cnt = 0; trail_cnt = 0; rise_cnt = 0;
    cap_q.delete();
    tx_data = 8'hC6; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (rise_cnt < 3 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("abort_in_shift", 32'(rise_cnt >= 3), 32'(1));
    rst = 1'b0;
    #1;
    checkOutput("abort_sck_en", 32'(sck_en), 32'(0));
    checkOutput("abort_cs_n", 32'(spi_cs_n), 32'(1));
    checkOutput("abort_busy", 32'(busy), 32'(0));
    checkOutput("abort_done", 32'(done), 32'(0));
    checkOutput("abort_rx", 32'(rx_data), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (done) saw_done = 1;
      if (!spi_cs_n) cs_low = 1;
    end
    checkOutput("abort_no_done", 32'(saw_done), 32'(0));
    checkOutput("abort_cs_idle", 32'(cs_low), 32'(0));
  endtask

  initial begin
    logic [7:0] r_tx, r_sw;
    rst = 1'b0; start = 1'b0; tx_data = '0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_sck_en", 32'(sck_en), 32'(0));
    checkOutput("rst_cs_n", 32'(spi_cs_n), 32'(1));
    checkOutput("rst_mosi", 32'(spi_mosi), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_done", 32'(done), 32'(0));
    checkOutput("rst_rx", 32'(rx_data), 32'(0));
    checkOutput("rst_spi_sck", 32'(spi_sck), 32'(0));
    rst = 1'b1;
    @(negedge clk);

    applyStimulus(8'hA5, 0, 0, 0, 1, 8'h00, 0);
    abortTransfer();
    applyStimulus(8'h3C, 1, 1, 0, 0, 8'hC3, 0);
    applyStimulus(8'h01, 0, 0, 1, 1, 8'h00, 0);

    applyStimulus(8'h5A, 0, 1, 0, 1, 8'h00, 1);
    applyStimulus(8'hFF, 0, 0, 0, 1, 8'h00, 0);
    checkOutput("b2b_cs_high", 32'(last_hi), 32'(2));

    for (int b = 0; b < 4; b++) begin
      baud = b;
      r_tx = 8'($urandom);
      applyStimulus(r_tx, 0, 0, 0, 1, 8'h00, 0);
    end

    for (int i = 0; i < 16; i++) begin
      baud = int'($urandom_range(0, 3));
      r_tx = 8'($urandom);
      r_sw = 8'($urandom);
      applyStimulus(r_tx, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r_sw, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
